// File: rtl/gen3_block_sync.sv
// gen3_block_sync
//   Gen3 128b/130b block-boundary controller for the TX MAC path. It counts
//   the symbol position inside each 16-symbol block and latches the framing
//   stage's sync select into the 2-bit sync header at every block boundary.
//   After every BLOCKS_PER_STALL blocks it inserts one gearbox stall cycle,
//   which absorbs the 2-bit-per-block header overhead.
//
// Ports
//   CLK           in   clock, all state on the rising edge
//   RST_L         in   asynchronous active-low reset
//   i_EN          in   Gen3 datapath active; low returns the block to IDLE
//   i_Sync_Sel    in   1 = next block is an ordered set, 0 = data block
//   o_Symbol_Num  out  symbol index of the current cycle within the block
//   o_Block_Start out  high while in RUN with symbol 0
//   o_Sync_Header out  2'b10 data, 2'b01 ordered set, 2'b00 outside RUN/STALL
//   o_Stall       out  high in ALIGN and STALL; framing must not advance
//   o_Block_Cnt   out  index of the current block within the stall group
//   dbg_state     out  FSM state (0 IDLE, 1 ALIGN, 2 RUN, 3 STALL)
//
// Handshake: there is no valid/ready pair. o_Stall is the only flow-control
// signal; while it is high the consumer holds its data and symbol pointer.
//
// Every output is decoded from registers only, so there is no combinational
// path from any input to any output.

module gen3_block_sync #(
  parameter int SYMBOL_NUM_WIDTH = 4,
  parameter int BLOCKS_PER_STALL = 4,
  parameter int BLK_CNT_WIDTH    = 2
) (
  input  logic                        CLK,
  input  logic                        RST_L,
  input  logic                        i_EN,
  input  logic                        i_Sync_Sel,
  output logic [SYMBOL_NUM_WIDTH-1:0] o_Symbol_Num,
  output logic                        o_Block_Start,
  output logic [1:0]                  o_Sync_Header,
  output logic                        o_Stall,
  output logic [BLK_CNT_WIDTH-1:0]    o_Block_Cnt,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  localparam logic [SYMBOL_NUM_WIDTH-1:0] SYM_LAST = '1;
  localparam logic [BLK_CNT_WIDTH-1:0]    BLK_LAST = BLK_CNT_WIDTH'(BLOCKS_PER_STALL - 1);

  state_t                      state_q, state_d;
  logic [SYMBOL_NUM_WIDTH-1:0] sym_q, sym_d;
  logic [BLK_CNT_WIDTH-1:0]    blk_q, blk_d;
  logic [1:0]                  hdr_q, hdr_d;
  logic [1:0]                  hdr_enc;

  // Ordered set -> 2'b01, data block -> 2'b10.
  assign hdr_enc = i_Sync_Sel ? 2'b01 : 2'b10;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      blk_q   <= '0;
      hdr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      blk_q   <= blk_d;
      hdr_q   <= hdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    blk_d   = blk_q;
    hdr_d   = hdr_q;

    if (!i_EN) begin
      // Dropping enable abandons the current block immediately.
      state_d = ST_IDLE;
      sym_d   = '0;
      blk_d   = '0;
      hdr_d   = 2'b00;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ALIGN;
          sym_d   = '0;
          blk_d   = '0;
          hdr_d   = 2'b00;
        end
        ST_ALIGN: begin
          // Header of the very first block is taken here.
          state_d = ST_RUN;
          sym_d   = '0;
          blk_d   = '0;
          hdr_d   = hdr_enc;
        end
        ST_RUN: begin
          if (sym_q == SYM_LAST) begin
            // Block boundary: capture the next block's header.
            sym_d = '0;
            hdr_d = hdr_enc;
            if (blk_q == BLK_LAST) begin
              state_d = ST_STALL;
              blk_d   = '0;
            end else begin
              blk_d = blk_q + 1'b1;
            end
          end else begin
            sym_d = sym_q + 1'b1;
          end
        end
        ST_STALL: begin
          // Single gearbox bubble; header already holds the next block's value.
          state_d = ST_RUN;
          sym_d   = '0;
          blk_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          sym_d   = '0;
          blk_d   = '0;
          hdr_d   = 2'b00;
        end
      endcase
    end
  end

  assign o_Symbol_Num  = sym_q;
  assign o_Block_Cnt   = blk_q;
  assign o_Block_Start = (state_q == ST_RUN) && (sym_q == '0);
  assign o_Stall       = (state_q == ST_ALIGN) || (state_q == ST_STALL);
  assign o_Sync_Header = ((state_q == ST_RUN) || (state_q == ST_STALL)) ? hdr_q : 2'b00;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gen3_block_sync.sv
// Directed bench for gen3_block_sync. Cycle 0 is the cycle in which i_EN is
// first seen high; outputs are sampled on the falling edge of each cycle.

module tb_gen3_block_sync;

  logic       CLK;
  logic       RST_L;
  logic       i_EN;
  logic       i_Sync_Sel;
  logic [3:0] o_Symbol_Num;
  logic       o_Block_Start;
  logic [1:0] o_Sync_Header;
  logic       o_Stall;
  logic [1:0] o_Block_Cnt;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  gen3_block_sync #(
    .SYMBOL_NUM_WIDTH(4),
    .BLOCKS_PER_STALL(4),
    .BLK_CNT_WIDTH(2)
  ) dut (
    .CLK          (CLK),
    .RST_L        (RST_L),
    .i_EN         (i_EN),
    .i_Sync_Sel   (i_Sync_Sel),
    .o_Symbol_Num (o_Symbol_Num),
    .o_Block_Start(o_Block_Start),
    .o_Sync_Header(o_Sync_Header),
    .o_Stall      (o_Stall),
    .o_Block_Cnt  (o_Block_Cnt),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish before 100000");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] sym, input logic bs,
                           input logic [1:0] hdr, input logic st, input logic [1:0] blk);
    check({tag, ".sym"},   32'(o_Symbol_Num),  32'(sym));
    check({tag, ".bstart"},32'(o_Block_Start), 32'(bs));
    check({tag, ".hdr"},   32'(o_Sync_Header), 32'(hdr));
    check({tag, ".stall"}, 32'(o_Stall),       32'(st));
    check({tag, ".blk"},   32'(o_Block_Cnt),   32'(blk));
  endtask

  initial begin
    int p;
    logic [3:0] e_sym;
    logic [1:0] e_blk;
    logic       e_stall;
    logic       e_bs;
    logic [1:0] e_hdr;

    RST_L      = 1'b0;
    i_EN       = 1'b0;
    i_Sync_Sel = 1'b0;
    #23;
    check_all("reset", 4'd0, 1'b0, 2'b00, 1'b0, 2'd0);
    check("reset.state", 32'(dbg_state), 32'd0);

    @(negedge CLK);
    RST_L = 1'b1;
    @(posedge CLK);
    #1;
    i_EN = 1'b1;

    // cycle 0: still IDLE
    @(negedge CLK);
    check_all("c0", 4'd0, 1'b0, 2'b00, 1'b0, 2'd0);
    check("c0.state", 32'(dbg_state), 32'd0);

    // cycle 1: ALIGN
    @(negedge CLK);
    check_all("c1_align", 4'd0, 1'b0, 2'b00, 1'b1, 2'd0);
    check("c1.state", 32'(dbg_state), 32'd1);

    // cycles 2..236: continuous enable. Stall group is 65 cycles: 64 RUN + 1 STALL.
    for (int c = 2; c <= 236; c++) begin
      @(negedge CLK);
      p = (c - 2) % 65;
      if (p == 64) begin
        e_stall = 1'b1; e_sym = 4'd0; e_blk = 2'd0; e_bs = 1'b0;
      end else begin
        e_stall = 1'b0; e_sym = 4'(p % 16); e_blk = 2'(p / 16); e_bs = (p % 16) == 0;
      end
      // Block 2 (cycles 34..49) and STALL + block 4 (66..82) carry ordered-set headers.
      e_hdr = ((c >= 34 && c <= 49) || (c >= 66 && c <= 82)) ? 2'b01 : 2'b10;
      check_all($sformatf("run%0d", c), e_sym, e_bs, e_hdr, e_stall, e_blk);

      // sync select for this cycle: noise at block 1 symbols 0..14,
      // real requests at block 1 symbol 15 and block 3 symbol 15
      if (c >= 18 && c <= 32)      i_Sync_Sel = 1'($urandom_range(0, 1));
      else if (c == 33 || c == 65) i_Sync_Sel = 1'b1;
      else                         i_Sync_Sel = 1'b0;

      if (c == 236) i_EN = 1'b0;  // block 2 symbol 7 of the fourth group
    end

    // cycle 237: IDLE after enable drop, re-enable now
    @(negedge CLK);
    check_all("c237_idle", 4'd0, 1'b0, 2'b00, 1'b0, 2'd0);
    check("c237.state", 32'(dbg_state), 32'd0);
    i_EN = 1'b1;

    // cycle 238: ALIGN; request ordered set for the first block
    @(negedge CLK);
    check_all("c238_align", 4'd0, 1'b0, 2'b00, 1'b1, 2'd0);
    i_Sync_Sel = 1'b1;

    // cycle 239: first block start after re-enable
    @(negedge CLK);
    check_all("c239_start", 4'd0, 1'b1, 2'b01, 1'b0, 2'd0);
    i_Sync_Sel = 1'b0;

    repeat (5) @(negedge CLK);
    check_all("c244", 4'd5, 1'b0, 2'b01, 1'b0, 2'd0);

    // asynchronous reset pulse between clock edges
    #2 RST_L = 1'b0;
    #1;
    check_all("async_rst", 4'd0, 1'b0, 2'b00, 1'b0, 2'd0);
    check("async_rst.state", 32'(dbg_state), 32'd0);
    #1 RST_L = 1'b1;

    @(negedge CLK);
    check_all("post_rst_align", 4'd0, 1'b0, 2'b00, 1'b1, 2'd0);
    check("post_rst.state", 32'(dbg_state), 32'd1);
    @(negedge CLK);
    check_all("post_rst_start", 4'd0, 1'b1, 2'b10, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen3_block_sync.md
# gen3_block_sync

Gen3 128b/130b block-boundary controller for the TX MAC path. It sits next to the Gen3 framing stage. It generates the per-block symbol number that framing consumes and latches the framing stage's sync select into a 2-bit sync header at each block boundary. It also inserts one gearbox stall cycle after every 4 blocks, compensating the 2-bit-per-block header overhead on an 8-bit-per-lane datapath.

## Interface
Parameters:
- SYMBOL_NUM_WIDTH, 4, width of symbol index; block length = 2**SYMBOL_NUM_WIDTH = 16 symbols.
- BLOCKS_PER_STALL, 4, blocks between gearbox stall cycles (4 × 2 header bits = 8 bits = 1 symbol).
- BLK_CNT_WIDTH, 2, width of block counter; must satisfy 2**BLK_CNT_WIDTH >= BLOCKS_PER_STALL.

Ports:
- CLK  in  1  clock; one clock, all state on rising edge.
- RST_L  in  1  asynchronous active-low reset.
- i_EN  in  1  Gen3 datapath active; low forces IDLE.
- i_Sync_Sel  in  1  from framing: 1 = next block is an ordered set, 0 = data block.
- o_Symbol_Num  out  SYMBOL_NUM_WIDTH  symbol index of current cycle within block; feeds framing i_Symbol_Num.
- o_Block_Start  out  1  high in the cycle o_Symbol_Num = 0 while in RUN.
- o_Sync_Header  out  2  header of current block: 2'b10 data, 2'b01 ordered set; 2'b00 when not in RUN/STALL.
- o_Stall  out  1  high in ALIGN and STALL; framing and the TX buffer must not advance.
- o_Block_Cnt  out  BLK_CNT_WIDTH  index of current block within the stall group.

## Operation
- States: IDLE, ALIGN, RUN, STALL; 2-bit state register.
- IDLE: all counters held at 0. Moves to ALIGN when i_EN = 1.
- ALIGN: lasts exactly one cycle, with o_Stall = 1. Samples i_Sync_Sel into the header register. Moves to RUN with symbol = 0 and block_cnt = 0.
- RUN: symbol increments by 1 each cycle.
  - At symbol 15, i_Sync_Sel is sampled into the header register for the next block.
  - At symbol 15 with block_cnt = BLOCKS_PER_STALL-1: go to STALL, block_cnt to 0, symbol to 0.
  - At symbol 15 otherwise: stay in RUN, symbol wraps to 0, block_cnt increments.
- STALL: lasts exactly one cycle, with o_Stall = 1. Symbol holds at 0, block_cnt holds at 0, header holds. Moves to RUN, and that cycle is a block start.
- Header encoding: a sampled 1 gives 2'b01 and a sampled 0 gives 2'b10. The header changes only at a block boundary, so it is constant for all 16 symbols of a block.
- i_Sync_Sel is ignored in every cycle except ALIGN and RUN symbol 15.
- i_EN = 0 in any state: next state is IDLE, counters and header clear, o_Stall = 0. There is no partial-block completion.
- i_EN re-asserted on the cycle after dropping: IDLE → ALIGN as normal, so a new block sequence starts.

## Timing
- Reset (RST_L low, asynchronous) values:
  - state = IDLE, o_Symbol_Num = 0, o_Block_Start = 0, o_Sync_Header = 2'b00, o_Stall = 0, o_Block_Cnt = 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- i_EN rises at cycle t:
  - ALIGN (o_Stall = 1) at t+1.
  - First block start at t+2.
- Block period is 16 cycles. A stall group is 4 × 16 + 1 = 65 cycles, so the steady-state first-block-start period is 65.
- i_Sync_Sel sampled at symbol 15 of block n appears on o_Sync_Header at symbol 0 of block n+1. This is 1 cycle later, or 2 cycles if a STALL intervenes.
- RST_L asserted mid-block: outputs go to reset values immediately. After release, operation resumes through IDLE → ALIGN.

## Test plan
- Reset then i_EN = 1 at cycle 0, i_Sync_Sel = 0:
  - o_Stall = 1 at cycle 1.
  - o_Block_Start = 1, o_Symbol_Num = 0, header 2'b10 at cycle 2.
  - o_Symbol_Num = 15 at cycle 17.
- Continuous enable over 200 cycles:
  - o_Stall pulses 1 cycle at cycles 66, 131, 196 (symbol held at 0).
  - o_Block_Cnt sequence 0,1,2,3 per group.
- i_Sync_Sel = 1 only at symbol 15 of block 1: block 2 header = 2'b01, blocks 1 and 3 = 2'b10. Toggling i_Sync_Sel at symbols 0–14 has no effect.
- Sync select across a stall boundary: i_Sync_Sel = 1 at symbol 15 of block 3 → header 2'b01 during STALL and block 4. o_Block_Cnt = 0 for block 4.
- i_EN dropped at symbol 7 of block 2:
  - Next cycle IDLE: symbol 0, header 2'b00, o_Block_Start = 0.
  - Re-enable → ALIGN then block start after 2 cycles.
- RST_L pulsed low mid-block for 1 cycle (asynchronous, not clock-aligned): outputs clear immediately, and with i_EN still high ALIGN follows the first clock after release.
